// File: rtl/dz_countdown_pkg.sv
// dz_countdown_pkg
//   Shared definitions for the dot-matrix countdown path (dz_countdown and
//   the dz_show stage): FSM state encodings and the digit width.
package dz_countdown_pkg;

  localparam int DZ_NUM_W = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/dz_btn_cond.sv
// dz_btn_cond
//   Button conditioner: 2-FF synchronizer, optional debounce filter, and a
//   rising-edge detector producing a single-cycle pulse per press.
//   Ports:
//     clk      in  system clock
//     rst_n    in  async active-low reset
//     i_btn    in  raw button level (asynchronous to clk)
//     o_pulse  out one-cycle pulse on an accepted rising edge
//   DB_LEN = 0 bypasses the filter; DB_LEN > 0 requires DB_LEN consecutive
//   equal synchronized samples before the filtered level changes.
module dz_btn_cond #(
  parameter int DB_LEN = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1, r_sync2, r_lvl_d;
  logic w_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  if (DB_LEN > 0) begin : g_db
    localparam int CW = $clog2(DB_LEN + 1);
    logic [CW-1:0] r_db_cnt;
    logic          r_filt;

    // Counter only advances while the input disagrees with the filtered
    // level; any agreeing sample restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt <= '0;
        r_filt   <= 1'b0;
      end else if (r_sync2 != r_filt) begin
        if (r_db_cnt == CW'(DB_LEN - 1)) begin
          r_filt   <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
    assign w_lvl = r_filt;
  end else begin : g_nodb
    assign w_lvl = r_sync2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lvl_d <= 1'b0;
    else        r_lvl_d <= w_lvl;
  end

  assign o_pulse = w_lvl & ~r_lvl_d;

endmodule

// File: rtl/dz_countdown.sv
// dz_countdown
//   START_VAL..0 seconds countdown driving the digit input of dz_show, with
//   start/restart and pause/resume buttons plus running/done status.
//   Ports:
//     clk       in  system clock, rising edge
//     rst_n     in  async active-low reset
//     start     in  raw start/restart button
//     pause     in  raw pause/resume button
//     num       out current digit
//     running   out high while counting
//     done      out high once the count has reached 0
//     sec_tick  out one-cycle pulse on every decrement
//   Build option: define DEBOUNCE_EN to add a DB_CYCLES debounce filter on
//   both buttons (otherwise DB_CYCLES has no effect).
module dz_countdown
  import dz_countdown_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int START_VAL = 5,
  parameter int DB_CYCLES = 20_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pause,
  output logic [DZ_NUM_W-1:0] num,
  output logic                running,
  output logic                done,
  output logic                sec_tick
);

`ifdef DEBOUNCE_EN
  localparam int DB_ON = 1;
`else
  localparam int DB_ON = 0;
`endif
  localparam int DB_LEN = DB_CYCLES * DB_ON;

  localparam int                  PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]       PRE_TC  = PW'(TICK_DIV - 1);
  localparam logic [DZ_NUM_W-1:0] NUM_RLD = DZ_NUM_W'(START_VAL);

  logic                w_start_p, w_pause_p;
  logic [1:0]          r_state, w_state_nxt;
  logic [DZ_NUM_W-1:0] r_num, w_num_nxt;
  logic [PW-1:0]       r_presc, w_presc_nxt;
  logic                r_tick, w_tick_nxt;
  logic                r_running, r_done;

  dz_btn_cond #(.DB_LEN(DB_LEN)) u_start_cond (
    .clk(clk), .rst_n(rst_n), .i_btn(start), .o_pulse(w_start_p)
  );

  dz_btn_cond #(.DB_LEN(DB_LEN)) u_pause_cond (
    .clk(clk), .rst_n(rst_n), .i_btn(pause), .o_pulse(w_pause_p)
  );

  // start wins over pause from every state; pause wins over a terminal tick.
  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    if (w_start_p) begin
      w_state_nxt = ST_RUN;
      w_num_nxt   = NUM_RLD;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_pause_p) begin
            w_state_nxt = ST_PAUSE;
          end else if (r_presc == PRE_TC) begin
            w_presc_nxt = '0;
            w_tick_nxt  = 1'b1;
            if (r_num != '0) w_num_nxt = r_num - 1'b1;
            if (r_num <= DZ_NUM_W'(1)) w_state_nxt = ST_DONE;
          end else begin
            w_presc_nxt = r_presc + 1'b1;
          end
        end
        ST_PAUSE: if (w_pause_p) w_state_nxt = ST_RUN;
        ST_IDLE, ST_DONE: ;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_num     <= NUM_RLD;
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_num     <= w_num_nxt;
      r_presc   <= w_presc_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign num      = r_num;
  assign running  = r_running;
  assign done     = r_done;
  assign sec_tick = r_tick;

endmodule

// File: tb/tb_dz_countdown.sv
// tb_dz_countdown
//   Randomized button presses against a cycle-level behavioural model of the
//   countdown; expected tick digits are queued and popped by a monitor.
//   Define DEBOUNCE_EN for both the DUT and this bench to test the filter.
module tb_dz_countdown;

  localparam int TICK_DIV  = 4;
  localparam int START_VAL = 5;
  localparam int DB_CYCLES = 3;
`ifdef DEBOUNCE_EN
  localparam int DB_ON = 1;
`else
  localparam int DB_ON = 0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0;
  logic [2:0] num;
  logic       running, done, sec_tick;

  dz_countdown #(.TICK_DIV(TICK_DIV), .START_VAL(START_VAL), .DB_CYCLES(DB_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .num(num), .running(running), .done(done), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int exp_q[$];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 run, 2 pause, 3 done; phase = cycles spent counting in
  // the current second.
  int         m_mode = 0, m_num = START_VAL, m_phase = 0;
  logic [7:0] hs = '0, hp = '0;   // raw samples, bit i = sample i edges ago
  logic       fs = 0, fs_d = 0, fp = 0, fp_d = 0;

  always @(posedge clk or negedge rst_n) begin : model
    logic sp, pp;
    if (!rst_n) begin
      m_mode = 0; m_num = START_VAL; m_phase = 0;
      hs = '0; hp = '0; fs = 0; fs_d = 0; fp = 0; fp_d = 0;
      exp_q.delete();
    end else begin
      hs = {hs[6:0], start};
      hp = {hp[6:0], pause};
`ifdef DEBOUNCE_EN
      // Filtered level flips once DB_CYCLES synchronized samples all disagree.
      sp = fs & ~fs_d;
      pp = fp & ~fp_d;
      fs_d = fs;
      fp_d = fp;
      if (hs[2 +: DB_CYCLES] == {DB_CYCLES{~fs}}) fs = ~fs;
      if (hp[2 +: DB_CYCLES] == {DB_CYCLES{~fp}}) fp = ~fp;
`else
      // A press first sampled two edges ago acts on this edge.
      sp = hs[2] & ~hs[3];
      pp = hp[2] & ~hp[3];
`endif
      if (sp) begin
        m_mode = 1; m_num = START_VAL; m_phase = 0;
      end else if (pp && m_mode == 1) begin
        m_mode = 2;
      end else if (pp && m_mode == 2) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_phase++;
        if (m_phase == TICK_DIV) begin
          m_phase = 0;
          if (m_num > 0) m_num--;
          exp_q.push_back(m_num);
          if (m_num == 0) m_mode = 3;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("running", running, m_mode == 1);
      chk("done", done, m_mode == 3);
      chk("num", num, m_num);
      if (sec_tick || exp_q.size() != 0) begin
        chk("sec_tick", sec_tick, exp_q.size() != 0);
        if (sec_tick && exp_q.size() != 0) chk("tick_num", num, exp_q.pop_front());
        else exp_q.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input bit s, input bit p);
    @(posedge clk); #2;
    start = s; pause = p;
    repeat ($urandom_range(5, 8)) @(posedge clk);
    #2;
    start = 0; pause = 0;
    repeat ($urandom_range(5, 10)) @(posedge clk);
  endtask

  initial begin
    int lat;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_num", num, START_VAL);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", sec_tick, 0);

`ifdef DEBOUNCE_EN
    @(posedge clk); #2 start = 1;
    repeat (2) @(posedge clk);
    #2 start = 0;
    repeat (12) @(negedge clk);
    chk("glitch_running", running, 0);
    chk("glitch_num", num, START_VAL);
`endif

    // Press-to-RUN latency, counted in clock edges after the press.
    @(posedge clk); #2 start = 1;
    lat = 0;
    while (!running && lat < 30) begin
      @(posedge clk); lat++; #1;
    end
    chk("start_latency", lat, 3 + DB_ON * DB_CYCLES);
    repeat (2) @(posedge clk);
    #2 start = 0;

    // Full countdown then a long stay in DONE.
    repeat (150) @(negedge clk);
    chk("done_hold", done, 1);
    chk("done_num", num, 0);

    for (int ep = 0; ep < 400; ep++) begin
      int r;
      r = $urandom_range(0, 9);
      if (ep == 200) begin
        press(1, 0);
        repeat (4) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("async_rst_num", num, START_VAL);
        chk("async_rst_running", running, 0);
        chk("async_rst_done", done, 0);
        @(posedge clk); #2 rst_n = 1;
      end else if (r < 2) press(1, 0);
      else if (r < 6) press(0, 1);
      else if (r == 6) press(1, 1);
      else repeat ($urandom_range(1, 40)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
